// File: rtl/mod_matrix_seq.sv
// mod_matrix_seq: modulation-matrix slot sequencer with index delay lines, strobe shifters and update-grant FSM (option: MOD_SEQ_FRAME_SYNC_EN)
module mod_matrix_seq #(
   parameter int VOICES   = 8,
   parameter int V_OSC    = 4,
   parameter int V_WIDTH  = 3,
   parameter int O_WIDTH  = 2,
   parameter int O_ENVS   = 2,
   parameter int V_ENVS   = V_OSC*O_ENVS,
   parameter int x_offset = (V_OSC*VOICES)-2
) (
   input  logic                              sCLK_XVXENVS,
   input  logic                              reset_reg_N,
   input  logic                              run,
   input  logic                              step,
   input  logic                              upd_req,
   output logic [x_offset:0][O_WIDTH-1:0]    ox_dly,
   output logic [x_offset:0][V_WIDTH-1:0]    vx_dly,
   output logic [V_ENVS:0]                   sh_osc_reg,
   output logic [V_OSC+2:0]                  sh_voice_reg,
   output logic                              frame_sync,
   output logic                              upd_gnt
);
`ifdef MOD_SEQ_FRAME_SYNC_EN
   localparam bit FS_EN = 1'b1;
`else
   localparam bit FS_EN = 1'b0;
`endif
   localparam logic [O_WIDTH-1:0] O_LAST = O_WIDTH'(V_OSC-1);
   localparam logic [V_WIDTH-1:0] V_LAST = V_WIDTH'(VOICES-1);
   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_GNT, S_HOLD} state_t;
   state_t st, nxt;
   logic [O_WIDTH-1:0] osc_cnt;
   logic [V_WIDTH-1:0] voice_cnt;
   logic adv, osc_wrap, frame;
   assign adv      = run & step;
   assign osc_wrap = adv & (osc_cnt == O_LAST);
   assign frame    = osc_wrap & (voice_cnt == V_LAST);
   // slot counters and index delay lines move only on an advance
   always_ff @(posedge sCLK_XVXENVS or negedge reset_reg_N) begin
      if (!reset_reg_N) begin
         osc_cnt   <= '0;
         voice_cnt <= '0;
         ox_dly    <= '0;
         vx_dly    <= '0;
      end else if (adv) begin
         osc_cnt   <= osc_wrap ? '0 : osc_cnt + 1'b1;
         voice_cnt <= !osc_wrap ? voice_cnt : (voice_cnt == V_LAST) ? '0 : voice_cnt + 1'b1;
         ox_dly    <= {ox_dly[x_offset-1:0], osc_cnt};
         vx_dly    <= {vx_dly[x_offset-1:0], voice_cnt};
      end
   end
   // strobe shifters run every clock so pending strobes drain while stopped
   always_ff @(posedge sCLK_XVXENVS or negedge reset_reg_N) begin
      if (!reset_reg_N) begin
         sh_osc_reg   <= '0;
         sh_voice_reg <= '0;
         frame_sync   <= 1'b0;
      end else begin
         sh_osc_reg   <= {sh_osc_reg[V_ENVS-1:0], adv};
         sh_voice_reg <= {sh_voice_reg[V_OSC+1:0], osc_wrap};
         frame_sync   <= frame;
      end
   end
   // grant FSM state register
   always_ff @(posedge sCLK_XVXENVS or negedge reset_reg_N) begin
      if (!reset_reg_N) st <= S_IDLE;
      else st <= nxt;
   end
   // grant FSM next state; with frame sync enabled a running engine is only granted at a frame boundary
   always_comb begin
      nxt = st;
      case (st)
         S_IDLE:  nxt = !upd_req ? S_IDLE : (FS_EN && frame) ? S_GNT : S_WAIT;
         S_WAIT:  nxt = !upd_req ? S_IDLE : (!FS_EN || !run || frame) ? S_GNT : S_WAIT;
         S_GNT:   nxt = S_HOLD;
         default: nxt = upd_req ? S_HOLD : S_IDLE;
      endcase
   end
   // grant output decode
   always_comb begin
      upd_gnt = (st == S_GNT);
   end
endmodule
